// File: rtl/eth_header_stream_parser.sv
// eth_header_stream_parser: streaming Ethernet/802.1Q/802.1ad header parser with payload pass-through
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_data, in_valid, in_last, in_ready  frame byte stream, byte 0 first
//   hdr_valid, hdr_ready                 header record handshake
//   dest_mac, src_mac, ethertype_raw, vlan_count, vlan_id, hdr_is_len, hdr_err, hdr_has_payload
//                                        registered header record, stable while hdr_valid
//   out_data, out_valid, out_last, out_ready  payload byte stream (combinational pass-through)
module eth_header_stream_parser #(
   parameter int          MAX_VLAN_TAGS = 2,
   parameter logic [15:0] TPID_A        = 16'h8100,
   parameter logic [15:0] TPID_B        = 16'h88A8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     in_data,
   input  logic                           in_valid,
   input  logic                           in_last,
   output logic                           in_ready,
   output logic                           hdr_valid,
   input  logic                           hdr_ready,
   output logic [47:0]                    dest_mac,
   output logic [47:0]                    src_mac,
   output logic [15:0]                    ethertype_raw,
   output logic [2:0]                     vlan_count,
   output logic [MAX_VLAN_TAGS-1:0][11:0] vlan_id,
   output logic                           hdr_is_len,
   output logic                           hdr_err,
   output logic                           hdr_has_payload,
   output logic [7:0]                     out_data,
   output logic                           out_valid,
   output logic                           out_last,
   input  logic                           out_ready
);
   typedef enum logic [2:0] {S_MAC, S_TYPE, S_TCI, S_HDR, S_PAY} state_t;
   localparam logic [2:0] MAXV = 3'(MAX_VLAN_TAGS);
   state_t                         state_q, state_d;
   logic [3:0]                     cnt_q, cnt_d;
   logic [47:0]                    dest_q, dest_d, src_q, src_d;
   logic [7:0]                     hi_q, hi_d;
   logic [15:0]                    ety_q, ety_d;
   logic [2:0]                     vcnt_q, vcnt_d;
   logic [MAX_VLAN_TAGS-1:0][11:0] vid_q, vid_d;
   logic                           len_q, len_d, err_q, err_d, pay_q, pay_d;
   logic                           acc, in_hdr, in_pay;
   logic [15:0]                    word;

   assign in_hdr          = state_q inside {S_MAC, S_TYPE, S_TCI};
   assign in_pay          = state_q == S_PAY;
   assign in_ready        = in_hdr || (in_pay && out_ready);
   assign acc             = in_valid && in_ready;
   // first byte of a type/TCI pair is parked in hi_q; word is the completed pair
   assign word            = {hi_q, in_data};
   assign hdr_valid       = state_q == S_HDR;
   assign out_valid       = in_pay && in_valid;
   assign out_last        = in_pay && in_last;
   assign out_data        = in_pay ? in_data : 8'h00;
   assign dest_mac        = dest_q;
   assign src_mac         = src_q;
   assign ethertype_raw   = ety_q;
   assign vlan_count      = vcnt_q;
   assign vlan_id         = vid_q;
   assign hdr_is_len      = len_q;
   assign hdr_err         = err_q;
   assign hdr_has_payload = pay_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      src_d   = src_q;
      hi_d    = hi_q;
      ety_d   = ety_q;
      vcnt_d  = vcnt_q;
      vid_d   = vid_q;
      len_d   = len_q;
      err_d   = err_q;
      pay_d   = pay_q;
      if (acc && state_q == S_MAC) begin
         // bytes land at their final position so a runt leaves unreceived bytes at 0
         for (int k = 0; k < 6; k++) if (cnt_q == 4'(k)) dest_d[47-8*k -: 8] = in_data;
         for (int k = 0; k < 6; k++) if (cnt_q == 4'(k + 6)) src_d[47-8*k -: 8] = in_data;
         cnt_d   = (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
         state_d = (cnt_q == 4'd11) ? S_TYPE : S_MAC;
      end
      if (acc && state_q == S_TYPE) begin
         hi_d  = in_data;
         cnt_d = cnt_q[0] ? 4'd0 : 4'd1;
         if (cnt_q[0]) begin
            if ((word == TPID_A || word == TPID_B) && vcnt_q < MAXV) state_d = S_TCI;
            else begin
               ety_d   = word;
               len_d   = word < 16'h0600;
               pay_d   = !in_last;
               state_d = S_HDR;
            end
         end
      end
      if (acc && state_q == S_TCI) begin
         hi_d  = in_data;
         cnt_d = cnt_q[0] ? 4'd0 : 4'd1;
         if (cnt_q[0]) begin
            for (int k = 0; k < MAX_VLAN_TAGS; k++) if (vcnt_q == 3'(k)) vid_d[k] = {hi_q[3:0], in_data};
            vcnt_d  = vcnt_q + 3'd1;
            state_d = S_TYPE;
         end
      end
      // frame ended before the header completed: publish what arrived as a runt
      if (acc && in_last && in_hdr && state_d != S_HDR) begin
         state_d = S_HDR;
         err_d   = 1'b1;
         pay_d   = 1'b0;
      end
      if (state_q == S_HDR && hdr_ready) state_d = pay_q ? S_PAY : S_MAC;
      if (acc && in_pay && in_last) state_d = S_MAC;
      if (state_d == S_MAC && (state_q == S_HDR || in_pay)) begin
         cnt_d  = '0;
         dest_d = '0;
         src_d  = '0;
         hi_d   = '0;
         ety_d  = '0;
         vcnt_d = '0;
         vid_d  = '0;
         len_d  = 1'b0;
         err_d  = 1'b0;
         pay_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_MAC;
         cnt_q   <= '0;
         dest_q  <= '0;
         src_q   <= '0;
         hi_q    <= '0;
         ety_q   <= '0;
         vcnt_q  <= '0;
         vid_q   <= '0;
         len_q   <= 1'b0;
         err_q   <= 1'b0;
         pay_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
         src_q   <= src_d;
         hi_q    <= hi_d;
         ety_q   <= ety_d;
         vcnt_q  <= vcnt_d;
         vid_q   <= vid_d;
         len_q   <= len_d;
         err_q   <= err_d;
         pay_q   <= pay_d;
      end
   end
endmodule
